// File: rtl/reg_readback_pkg.sv
// Shared widths, register count and FSM encoding for the register readback engine.
package reg_readback_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 32;
    localparam int REG_COUNT  = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } rb_state_t;

endpackage

// File: rtl/reg_readback_if.sv
// Control, register-bank read port and output word stream of the readback engine.
// master = the readback engine, slave = its environment (controller, bank, consumer).
interface reg_readback_if;
    import reg_readback_pkg::*;

    logic      start;
    reg_addr_t first_reg;
    reg_addr_t last_reg;
    logic      abort;
    reg_addr_t rd_addr;
    reg_data_t rd_data;
    logic      out_valid;
    logic      out_ready;
    reg_data_t out_data;
    reg_addr_t out_addr;
    logic      busy;
    logic      done;

    modport master (
        input  start, first_reg, last_reg, abort, rd_data, out_ready,
        output rd_addr, out_valid, out_data, out_addr, busy, done
    );

    modport slave (
        output start, first_reg, last_reg, abort, rd_data, out_ready,
        input  rd_addr, out_valid, out_data, out_addr, busy, done
    );

endinterface

// File: rtl/reg_readback.sv
// Dumps an inclusive, wrapping range of bank registers as (addr, data) words.
// Latency: start edge k -> READ, edge k+1 captures the word, consumer can take it at edge k+2.
// Backpressure: a word is held stable until out_valid && out_ready; abort drops the dump at once.
module reg_readback
    import reg_readback_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    reg_readback_if.master bus
);

    rb_state_t state, state_nxt;
    reg_addr_t cur_addr;
    reg_addr_t last_q;
    reg_addr_t rd_addr_q;
    reg_addr_t out_addr_q;
    reg_data_t out_data_q;
    logic      out_valid_q;
    logic      handshake;
    logic      at_last;

    assign handshake = out_valid_q && bus.out_ready;
    assign at_last   = (cur_addr == last_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.rd_addr = rd_addr_q;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) state_nxt = ST_READ;
            end
            ST_READ: begin
                // Bank read port is combinational, so the address goes out live this cycle.
                bus.rd_addr = cur_addr;
                state_nxt   = bus.abort ? ST_IDLE : ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (handshake) begin
                    state_nxt = at_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                bus.done  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr    <= '0;
            last_q      <= '0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        cur_addr <= bus.first_reg;
                        last_q   <= bus.last_reg;
                    end
                end
                ST_READ: begin
                    rd_addr_q <= cur_addr;
                    if (!bus.abort) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= bus.rd_data;
                        out_addr_q  <= cur_addr;
                    end
                end
                ST_HOLD: begin
                    // A handshake coinciding with abort still delivers the word; abort only stops the walk.
                    if (handshake || bus.abort) out_valid_q <= 1'b0;
                    if (handshake && !bus.abort && !at_last) cur_addr <= cur_addr + reg_addr_t'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_reg_readback.sv
// Self-checking bench for reg_readback: per-cycle scoreboard model plus directed literal scenarios.
module tb_reg_readback;
    import reg_readback_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    reg_readback_if bus ();
    logic [DATA_W-1:0] bank [REG_COUNT];

    assign bus.rd_data = bank[bus.rd_addr];

    reg_readback dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Behavioural model: queue of addresses still to be offered, plus the word on offer.
    bit          m_busy  = 1'b0;
    bit          m_fetch = 1'b0;
    bit          m_offer = 1'b0;
    bit          m_done  = 1'b0;
    logic [3:0]  m_q[$];
    logic [3:0]  m_addr  = '0;
    logic [3:0]  m_rd    = '0;
    logic [31:0] m_data  = '0;
    int          start_cyc = 0;

    int          hs_cyc[$];
    logic [3:0]  hs_addr[$];
    logic [31:0] hs_data[$];
    int          done_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] hs_a(input int i);
        return (i < hs_addr.size()) ? 32'(hs_addr[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] hs_d(input int i);
        return (i < hs_data.size()) ? hs_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int hs_c(input int i);
        return (i < hs_cyc.size()) ? hs_cyc[i] : -100000;
    endfunction

    function automatic int dn_c(input int i);
        return (i < done_cyc.size()) ? done_cyc[i] : -100000;
    endfunction

    always @(negedge clk) begin : cmp
        logic [3:0] exp_rd;
        int n;
        cyc++;
        exp_rd = m_fetch ? m_q[0] : m_rd;
        chk("busy",      32'(bus.busy),      32'(m_busy));
        chk("done",      32'(bus.done),      32'(m_done));
        chk("out_valid", 32'(bus.out_valid), 32'(m_offer));
        chk("out_addr",  32'(bus.out_addr),  32'(m_addr));
        chk("out_data",  bus.out_data,       m_data);
        chk("rd_addr",   32'(bus.rd_addr),   32'(exp_rd));

        if (!rst && bus.out_valid && bus.out_ready) begin
            hs_cyc.push_back(cyc);
            hs_addr.push_back(bus.out_addr);
            hs_data.push_back(bus.out_data);
        end
        if (bus.done) done_cyc.push_back(cyc);

        // Advance the model by what the coming edge does with the inputs now applied.
        if (rst) begin
            m_busy = 0; m_fetch = 0; m_offer = 0; m_done = 0; m_q.delete();
            m_addr = '0; m_rd = '0; m_data = '0;
        end else if (!m_busy) begin
            if (bus.start) begin
                n = (((int'(bus.last_reg) - int'(bus.first_reg)) % REG_COUNT) + REG_COUNT) % REG_COUNT + 1;
                for (int i = 0; i < n; i++) m_q.push_back(4'((int'(bus.first_reg) + i) % REG_COUNT));
                m_busy = 1; m_fetch = 1; start_cyc = cyc;
            end
        end else if (bus.abort) begin
            if (m_fetch) m_rd = m_q[0];
            m_busy = 0; m_fetch = 0; m_offer = 0; m_done = 0; m_q.delete();
        end else if (m_done) begin
            m_busy = 0; m_done = 0;
        end else if (m_fetch) begin
            m_addr = m_q.pop_front(); m_data = bank[m_addr]; m_rd = m_addr;
            m_fetch = 0; m_offer = 1;
        end else if (m_offer && bus.out_ready) begin
            m_offer = 0;
            if (m_q.size() == 0) m_done = 1; else m_fetch = 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_cyc.delete(); hs_addr.delete(); hs_data.delete(); done_cyc.delete();
    endtask

    task automatic run_dump(input logic [3:0] f, input logic [3:0] l);
        bus.first_reg = f;
        bus.last_reg  = l;
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (bus.busy && k < maxc) begin
            tick(1);
            k++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL idle timeout: busy=%0b after %0d cycles, expected 0", bus.busy, k);
        end
    endtask

    task automatic wait_word(input logic [3:0] a, input int maxc);
        int k = 0;
        while (!(bus.out_valid && bus.out_addr == a) && k < maxc) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b1;
        bus.first_reg = '0; bus.last_reg = '0;
        for (int r = 0; r < REG_COUNT; r++) bank[r] = $urandom;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Basic 1..3 dump with the consumer always ready.
        bank[1] = 32'h11; bank[2] = 32'h22; bank[3] = 32'h33;
        clear_logs();
        run_dump(4'd1, 4'd3);
        wait_idle(50);
        tick(2);
        chk("t1 count", 32'(hs_addr.size()), 3);
        chk("t1 addr0", hs_a(0), 1);  chk("t1 data0", hs_d(0), 32'h11);
        chk("t1 addr1", hs_a(1), 2);  chk("t1 data1", hs_d(1), 32'h22);
        chk("t1 addr2", hs_a(2), 3);  chk("t1 data2", hs_d(2), 32'h33);
        chk("t1 first latency", 32'(hs_c(0) - start_cyc), 2);
        chk("t1 gap01", 32'(hs_c(1) - hs_c(0)), 2);
        chk("t1 gap12", 32'(hs_c(2) - hs_c(1)), 2);
        chk("t1 done count", 32'(done_cyc.size()), 1);
        chk("t1 done timing", 32'(dn_c(0) - hs_c(2)), 1);

        // Wrap 14..1.
        clear_logs();
        run_dump(4'd14, 4'd1);
        wait_idle(50);
        tick(2);
        chk("t2 count", 32'(hs_addr.size()), 4);
        chk("t2 addr0", hs_a(0), 14); chk("t2 addr1", hs_a(1), 15);
        chk("t2 addr2", hs_a(2), 0);  chk("t2 addr3", hs_a(3), 1);
        chk("t2 done count", 32'(done_cyc.size()), 1);

        // Five stalled cycles on the R2 word.
        clear_logs();
        run_dump(4'd1, 4'd3);
        wait_word(4'd2, 20);
        bus.out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick(1);
            chk("t3 hold valid", 32'(bus.out_valid), 1);
            chk("t3 hold addr", 32'(bus.out_addr), 2);
            chk("t3 hold data", bus.out_data, 32'h22);
        end
        bus.out_ready = 1'b1;
        wait_idle(50);
        tick(2);
        chk("t3 count", 32'(hs_addr.size()), 3);
        chk("t3 addr1", hs_a(1), 2);
        chk("t3 stall gap", 32'(hs_c(1) - hs_c(0)), 7);
        chk("t3 done count", 32'(done_cyc.size()), 1);

        // Abort on the second word of 0..7, coinciding with its handshake.
        clear_logs();
        run_dump(4'd0, 4'd7);
        wait_word(4'd1, 20);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        chk("t4 busy after abort", 32'(bus.busy), 0);
        chk("t4 valid after abort", 32'(bus.out_valid), 0);
        tick(10);
        chk("t4 count", 32'(hs_addr.size()), 2);
        chk("t4 addr0", hs_a(0), 0);
        chk("t4 addr1", hs_a(1), 1);
        chk("t4 done count", 32'(done_cyc.size()), 0);

        // start while busy must not disturb the running range.
        bank[6] = 32'hDEAD_0006;
        clear_logs();
        run_dump(4'd4, 4'd6);
        tick(2);
        bus.first_reg = 4'd9; bus.last_reg = 4'd12; bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        wait_idle(50);
        tick(2);
        chk("t5 count", 32'(hs_addr.size()), 3);
        chk("t5 addr0", hs_a(0), 4); chk("t5 addr1", hs_a(1), 5); chk("t5 addr2", hs_a(2), 6);

        // Reset during READ clears every output.
        clear_logs();
        run_dump(4'd0, 4'd5);
        rst = 1'b1;
        tick(1);
        chk("t6 busy", 32'(bus.busy), 0);
        chk("t6 valid", 32'(bus.out_valid), 0);
        chk("t6 data", bus.out_data, 0);
        chk("t6 addr", 32'(bus.out_addr), 0);
        chk("t6 rd_addr", 32'(bus.rd_addr), 0);
        chk("t6 done", 32'(bus.done), 0);
        rst = 1'b0;
        tick(5);
        chk("t6 done count", 32'(done_cyc.size()), 0);

        // Single-word dump.
        bank[5] = 32'h5555_AAAA;
        clear_logs();
        run_dump(4'd5, 4'd5);
        wait_idle(50);
        tick(2);
        chk("t7 count", 32'(hs_addr.size()), 1);
        chk("t7 addr", hs_a(0), 5);
        chk("t7 data", hs_d(0), 32'h5555_AAAA);
        chk("t7 done count", 32'(done_cyc.size()), 1);

        // Random ranges, random backpressure, sporadic abort and ignored start.
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < REG_COUNT; r++) bank[r] = $urandom;
            bus.out_ready = 1'b1;
            run_dump(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            for (int c = 0; c < 300 && bus.busy; c++) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
                bus.abort     = ($urandom_range(0, 40) == 0);
                bus.start     = ($urandom_range(0, 7) == 0);
                bus.first_reg = 4'($urandom_range(0, 15));
                bus.last_reg  = 4'($urandom_range(0, 15));
                tick(1);
            end
            bus.start = 1'b0;
            bus.abort = 1'b0;
            wait_idle(5);
            tick(1);
        end

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
